mux_rr_arbiter_8: RTL



---
 rtl/mux_rr_arbiter_8.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter_8.sv
// Round-robin / fixed-priority arbiter for an 8-input byte mux. It captures the
// winner's byte and holds it under valid/ready until the consumer accepts it.
module mux_rr_arbiter_8 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] in_data,
  input  logic                fixed_prio,
  input  logic                out_ready,
  output logic [2:0]          sel,
  output logic [7:0]          grant,
  output logic [7:0]          ack,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [CNT_W-1:0]    xfer_cnt,
  output logic                busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [2:0]          ptr_q, ptr_d;
  logic [2:0]          sel_q, sel_d;
  logic [7:0]          grant_q, grant_d;
  logic [7:0]          ack_q, ack_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    xfer_cnt_q, xfer_cnt_d;
  logic                busy_q, busy_d;

  logic                win_found_s;
  logic [2:0]          win_s;
  logic [2:0]          cand_s;

  // Winner search: scan from ptr with wrap (round-robin) or from 0 (fixed).
  always_comb begin
    win_found_s = 1'b0;
    win_s       = 3'd0;
    cand_s      = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (fixed_prio) begin
        cand_s = 3'(k);
      end else begin
        cand_s = ptr_q + 3'(k);
      end
      if (!win_found_s && req[cand_s]) begin
        win_found_s = 1'b1;
        win_s       = cand_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    grant_d     = grant_q;
    ack_d       = 8'h00;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    xfer_cnt_d  = xfer_cnt_q;
    busy_d      = busy_q;
    case (state_q)
      ST_IDLE: begin
        grant_d = 8'h00;
        if (win_found_s) begin
          state_d     = ST_BUSY;
          sel_d       = win_s;
          grant_d     = 8'h01 << win_s;
          ack_d       = 8'h01 << win_s;
          out_data_d  = in_data[32'(win_s) * DATA_W +: DATA_W];
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Request and data inputs are ignored here; only the accept matters.
        if (out_valid_q && out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          grant_d     = 8'h00;
          busy_d      = 1'b0;
          xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
          ptr_d       = sel_q + 3'd1;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        grant_d     = 8'h00;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd0;
      sel_q       <= 3'd0;
      grant_q     <= 8'h00;
      ack_q       <= 8'h00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      xfer_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      xfer_cnt_q  <= xfer_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign sel       = sel_q;
  assign grant     = grant_q;
  assign ack       = ack_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign busy      = busy_q;

endmodule
